// File: rtl/lsu_mmio_pkg.sv
// Shared types, address map and lane helpers for the load/store unit.
package lsu_mmio_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [15:0] DMEM_BASE = 16'h0000;
  localparam logic [15:0] OUT_BASE  = 16'h7000;
  localparam logic [15:0] IN_BASE   = 16'h7800;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3_e'(funct3))
      F3_B, F3_BU: byte_en = 4'b0001 << off;
      F3_H, F3_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (funct3_e'(funct3))
      F3_B:    load_extract = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   load_extract = {24'h0, sh[7:0]};
      F3_H:    load_extract = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   load_extract = {16'h0, sh[15:0]};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_be.sv
// Single-port synchronous data RAM with per-byte write enables.
// Read-during-write returns the old word; contents are not reset.
module lsu_dmem_be #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lsu_mmio_hs.sv
// Load/store unit for DMEM and MMIO: one request in flight, response 2 edges after accept.
// req_ready drops for the ACCESS and RESP cycles; stores commit on the accept edge.
module lsu_mmio_hs
  import lsu_mmio_pkg::*;
#(
  parameter int DMEM_DEPTH = 2048,
  parameter int NUM_OUT    = 4,
  parameter int NUM_IN     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [15:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [2:0]              req_funct3,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  input  logic [NUM_IN*32-1:0]    io_in_i,
  output logic [NUM_OUT*32-1:0]   io_out_o
);

  localparam int          AW       = $clog2(DMEM_DEPTH);
  localparam logic [16:0] DMEM_END = 17'(DMEM_DEPTH * 4);
  localparam logic [16:0] OUT_END  = 17'(int'(OUT_BASE) + 4 * NUM_OUT);
  localparam logic [16:0] IN_END   = 17'(int'(IN_BASE) + 4 * NUM_IN);

  state_e state_q, state_d;

  logic                  accept, in_dmem, in_out, in_in, bad_f3, misalign, err;
  logic [3:0]            idx, be;
  logic [31:0]           wdata_rep, io_word, dmem_rdata, word;
  logic [31:0]           out_q [NUM_OUT];
  logic [NUM_IN*32-1:0]  sync1_q, sync2_q;
  logic                  we_q, err_q, dmem_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [31:0]           io_word_q;

  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[5:2];
  assign in_dmem   = {1'b0, req_addr - DMEM_BASE} < DMEM_END;
  assign in_out    = (req_addr >= OUT_BASE) && ({1'b0, req_addr} < OUT_END);
  assign in_in     = (req_addr >= IN_BASE) && ({1'b0, req_addr} < IN_END);
  assign bad_f3    = req_funct3 inside {3'b011, 3'b110, 3'b111};
  assign misalign  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  // funct3[2] set means an unsigned load width, which has no store form
  assign err       = !(in_dmem || in_out || in_in) || (req_we && (in_in || req_funct3[2])) ||
                     bad_f3 || misalign;
  assign be        = byte_en(req_funct3, req_addr[1:0]);
  assign wdata_rep = store_lanes(req_wdata, req_funct3);

  // MMIO words are snapshotted on the accept edge, so an input change must
  // have cleared both synchroniser stages before the load is accepted.
  always_comb begin
    io_word = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (in_out && idx == 4'(k)) io_word = out_q[k];
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_in && idx == 4'(k)) io_word = sync2_q[32*k +: 32];
    end
  end

  // The RAM is addressed on the accept edge, so any earlier store has already
  // committed and a following load sees its data without a bypass mux.
  lsu_dmem_be #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .clk   (clk),
    .en    (accept),
    .we    (req_we && in_dmem && !err),
    .addr  (req_addr[AW+1:2]),
    .be    (be),
    .wdata (wdata_rep),
    .rdata (dmem_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (accept && req_we && in_out && !err && idx == 4'(k) && be[b])
            out_q[k][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    io_out_o = '0;
    for (int k = 0; k < NUM_OUT; k++) io_out_o[32*k +: 32] = out_q[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      dmem_q    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      io_word_q <= '0;
    end else if (accept) begin
      we_q      <= req_we;
      err_q     <= err;
      dmem_q    <= in_dmem;
      f3_q      <= req_funct3;
      off_q     <= req_addr[1:0];
      io_word_q <= io_word;
    end
  end

  assign word = dmem_q ? dmem_rdata : io_word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state_q == ACCESS) begin
      rsp_err   <= err_q;
      rsp_rdata <= (err_q || we_q) ? 32'h0 : load_extract(word, f3_q, off_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// Directed table plus hand-written sequences for lsu_mmio_hs.
module tb_lsu_mmio_hs;

  localparam int NUM_OUT = 4;
  localparam int NUM_IN  = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  req_valid, req_ready, req_we;
  logic [15:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_funct3;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [NUM_IN*32-1:0]  io_in_i;
  logic [NUM_OUT*32-1:0] io_out_o;

  int checks   = 0;
  int failures = 0;
  logic [NUM_OUT*32-1:0] out_snap;

  always #5 clk = ~clk;

  lsu_mmio_hs #(.DMEM_DEPTH(2048), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .io_in_i    (io_in_i),
    .io_out_o   (io_out_o)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge of the following IDLE cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int w;
    w  = 0;
    rd = 'x;
    er = 1'bx;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: req_ready got 0, required 1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    out_snap = io_out_o;
    chk("acc_ready_low", 32'(req_ready), 0);
    chk("acc_no_rsp", 32'(rsp_valid), 0);
    // junk store held while busy must be ignored
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0010; req_wdata = $urandom;
    @(negedge clk);
    chk("rsp_valid_t2", 32'(rsp_valid), 1);
    rd = rsp_rdata;
    er = rsp_err;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rsp_valid), 0);
    chk("ready_back", 32'(req_ready), 1);
  endtask

  task automatic req_chk(input string name, input logic we, input logic [2:0] f3,
                         input logic [15:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    issue(we, f3, addr, wd, rd, er);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
  endtask

  logic [15:0] b_addr [3];
  logic [31:0] b_exp  [3];
  int          acc_c  [3];
  int          n_acc, n_rsp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 3'b000, 16'h0011, 32'h0,        32'hFFFFFFBE, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 16'h0013, 32'h0,        32'h000000DE, 1'b0};
    vecs[3]  = '{1'b0, 3'b101, 16'h0012, 32'h0,        32'h0000DEAD, 1'b0};
    vecs[4]  = '{1'b0, 3'b001, 16'h0010, 32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 16'h0012, 32'h0,        32'hFFFFFFAD, 1'b0};
    vecs[6]  = '{1'b0, 3'b100, 16'h0010, 32'h0,        32'h000000EF, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 16'h0013, 32'h00000077, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 3'b010, 16'h0010, 32'h0,        32'h77ADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 16'h0012, 32'h0000C0DE, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 3'b010, 16'h0010, 32'h0,        32'hC0DEBEEF, 1'b0};
    vecs[11] = '{1'b1, 3'b010, 16'h0000, 32'h11223344, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 3'b010, 16'h0002, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 3'b001, 16'h0001, 32'h0000FFFF, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 3'b010, 16'h0000, 32'h0,        32'h11223344, 1'b0};
    vecs[15] = '{1'b0, 3'b010, 16'h5000, 32'h0,        32'h0,        1'b1};
    vecs[16] = '{1'b0, 3'b011, 16'h0000, 32'h0,        32'h0,        1'b1};
    vecs[17] = '{1'b1, 3'b100, 16'h0000, 32'h000000FF, 32'h0,        1'b1};
    vecs[18] = '{1'b0, 3'b010, 16'h0000, 32'h0,        32'h11223344, 1'b0};
    vecs[19] = '{1'b1, 3'b010, 16'h1FFC, 32'hA5A55A5A, 32'h0,        1'b0};
    vecs[20] = '{1'b0, 3'b010, 16'h1FFC, 32'h0,        32'hA5A55A5A, 1'b0};
    vecs[21] = '{1'b0, 3'b010, 16'h2000, 32'h0,        32'h0,        1'b1};
    vecs[22] = '{1'b0, 3'b001, 16'h1FFE, 32'h0,        32'hFFFFA5A5, 1'b0};
    vecs[23] = '{1'b0, 3'b010, 16'h7808, 32'h0,        32'h0,        1'b1};
    vecs[24] = '{1'b0, 3'b110, 16'h0000, 32'h0,        32'h0,        1'b1};
    vecs[25] = '{1'b0, 3'b101, 16'h1FFD, 32'h0,        32'h0,        1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    io_in_i = {32'h0000005A, 32'h0BADF00D};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    for (int k = 0; k < NUM_OUT; k++) chk($sformatf("rst_out%0d", k), io_out_o[32*k +: 32], 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);

    for (int i = 0; i < 26; i++)
      req_chk($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err);

    // output registers: byte-lane writes and readback
    req_chk("sh_out1", 1'b1, 3'b001, 16'h7006, 32'h00001234, 32'h0, 1'b0);
    chk("sh_out1_after_T", out_snap[63:32], 32'h12340000);
    chk("sh_out0_untouched", out_snap[31:0], 32'h0);
    req_chk("sb_out1", 1'b1, 3'b000, 16'h7004, 32'h000000AB, 32'h0, 1'b0);
    chk("sb_out1_after_T", out_snap[63:32], 32'h123400AB);
    req_chk("lw_out1", 1'b0, 3'b010, 16'h7004, 32'h0, 32'h123400AB, 1'b0);
    req_chk("sw_in0", 1'b1, 3'b010, 16'h7800, 32'hFFFFFFFF, 32'h0, 1'b1);
    req_chk("sw_out4", 1'b1, 3'b010, 16'h7010, 32'hFFFFFFFF, 32'h0, 1'b1);
    req_chk("sh_out_mis", 1'b1, 3'b001, 16'h7005, 32'hFFFFFFFF, 32'h0, 1'b1);
    chk("out0_final", io_out_o[31:0], 32'h0);
    chk("out1_final", io_out_o[63:32], 32'h123400AB);
    chk("out2_final", io_out_o[95:64], 32'h0);
    chk("out3_final", io_out_o[127:96], 32'h0);

    // synchronised inputs
    req_chk("lw_in0", 1'b0, 3'b010, 16'h7800, 32'h0, 32'h0BADF00D, 1'b0);
    req_chk("lb_in0", 1'b0, 3'b000, 16'h7801, 32'h0, 32'hFFFFFFF0, 1'b0);
    io_in_i[63:32] = 32'h000000A5;
    req_chk("in1_same_edge", 1'b0, 3'b010, 16'h7804, 32'h0, 32'h0000005A, 1'b0);
    io_in_i[63:32] = 32'h0000005A;
    repeat (3) @(negedge clk);
    req_chk("in1_settled", 1'b0, 3'b010, 16'h7804, 32'h0, 32'h0000005A, 1'b0);
    io_in_i[63:32] = 32'h000000A5;
    @(negedge clk);
    @(negedge clk);
    req_chk("in1_two_edges", 1'b0, 3'b010, 16'h7804, 32'h0, 32'h000000A5, 1'b0);

    // back-to-back with req_valid held high
    b_addr[0] = 16'h0010; b_exp[0] = 32'hC0DEBEEF;
    b_addr[1] = 16'h0000; b_exp[1] = 32'h11223344;
    b_addr[2] = 16'h7004; b_exp[2] = 32'h123400AB;
    n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 3; i++) acc_c[i] = 0;
    for (int c = 0; c < 40 && n_rsp < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid) begin
        if (n_rsp < 3) chk($sformatf("b2b_rsp%0d", n_rsp), rsp_rdata, b_exp[n_rsp]);
        n_rsp++;
      end
      if (n_acc < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = b_addr[n_acc];
        if (req_ready) begin
          acc_c[n_acc] = c;
          n_acc++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_rsp_count", n_rsp, 3);
    chk("b2b_gap1", acc_c[1] - acc_c[0], 3);
    chk("b2b_gap2", acc_c[2] - acc_c[1], 3);
    @(negedge clk);

    // reset while in ACCESS
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 16'h0020; req_wdata = 32'h600DCAFE;
    @(negedge clk);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out1", io_out_o[63:32], 32'h0);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 1);
    chk("rel_no_rsp", 32'(rsp_valid), 0);
    req_chk("lw_after_rst", 1'b0, 3'b010, 16'h0020, 32'h0, 32'h600DCAFE, 1'b0);
    req_chk("lw_out_rst", 1'b0, 3'b010, 16'h7004, 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
